// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: streams butterfly operand address pairs and twiddle indices for one NTT/INTT stage
//   clk, srst (sync, active-high)
//   start/stage/inverse : sweep request, sampled only in IDLE; illegal stage pulses err
//   valid/ready         : beat handshake; addr_a/addr_b/tw_idx carry LANES lanes of LOG2N bits
//   last                : final beat of the stage; busy while sweeping; done pulses after last accept
module ntt_addr_gen #(
  parameter int N     = 256,
  parameter int LOG2N = 8,
  parameter int LANES = 2,
  parameter int STW   = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   start,
  input  logic [STW-1:0]         stage,
  input  logic                   inverse,
  input  logic                   ready,
  output logic                   valid,
  output logic [LANES*LOG2N-1:0] addr_a,
  output logic [LANES*LOG2N-1:0] addr_b,
  output logic [LANES*LOG2N-1:0] tw_idx,
  output logic                   last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int B  = N / (2 * LANES);
  localparam int BW = $clog2(B);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [STW-1:0] stg_q, stg_d;
  logic inv_q, inv_d, err_d, run_d;
  logic [LANES*LOG2N-1:0] a_d, bb_d, tw_d;
  // Returns {tw_idx, addr_b, addr_a} for butterfly k; all arithmetic wraps at LOG2N bits,
  // so the inverse index (2<<s)-1-group stays correct even when 2<<s overflows.
  function automatic logic [3*LOG2N-1:0] lane_calc(input logic [LOG2N-1:0] k,
                                                   input logic [STW-1:0] s, input logic inv);
    logic [LOG2N-1:0] len, grp, a;
    len = LOG2N'(N >> (int'(s) + 1));
    grp = k >> (LOG2N - 1 - int'(s));
    a   = (grp << (LOG2N - int'(s))) + (k & (len - 1'b1));
    return {inv ? (LOG2N'(2) << s) - LOG2N'(1) - grp : (LOG2N'(1) << s) + grp, a + len, a};
  endfunction
  // Lane outputs are computed from next-state values so the registered outputs line up with b_q.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [3*LOG2N-1:0] r;
    assign r = lane_calc(LOG2N'(int'(b_d) * LANES + i), stg_d, inv_d);
    assign a_d[i*LOG2N +: LOG2N]  = r[0 +: LOG2N];
    assign bb_d[i*LOG2N +: LOG2N] = r[LOG2N +: LOG2N];
    assign tw_d[i*LOG2N +: LOG2N] = r[2*LOG2N +: LOG2N];
  end
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stg_d   = stg_q;
    inv_d   = inv_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        if (int'(stage) <= LOG2N - 1) begin
          state_d = RUN;
          b_d     = '0;
          stg_d   = stage;
          inv_d   = inverse;
        end else err_d = 1'b1;
      end
      RUN:  if (ready) begin
        if (b_q == BW'(B - 1)) state_d = FIN;
        else b_d = b_q + 1'b1;
      end
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    run_d = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      b_q     <= '0;
      stg_q   <= '0;
      inv_q   <= 1'b0;
      valid   <= 1'b0;
      addr_a  <= '0;
      addr_b  <= '0;
      tw_idx  <= '0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stg_q   <= stg_d;
      inv_q   <= inv_d;
      valid   <= run_d;
      addr_a  <= run_d ? a_d : '0;
      addr_b  <= run_d ? bb_d : '0;
      tw_idx  <= run_d ? tw_d : '0;
      last    <= run_d && b_d == BW'(B - 1);
      busy    <= run_d;
      done    <= state_d == FIN;
      err     <= err_d;
    end
  end
endmodule

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
Parametrised butterfly address and twiddle-index generator for the NTT/INTT datapath. It replaces the per-stage fixed ROMs. Given a stage number and a direction, it streams every butterfly of that stage: the operand address pair and the twiddle-table index for each lane, over a valid/ready handshake. It sits between the NTT controller and the coefficient RAM / twiddle ROM address ports.

Parameters:
N, 256, polynomial length; power of two, 4..1024
LOG2N, 8, log2(N)
LANES, 2, butterflies emitted per beat; power of two, 1..N/4
STW, 4, width of stage input, must hold LOG2N-1

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
start  in  1  begin a stage sweep; sampled only when idle
stage  in  STW  stage s, 0..LOG2N-1; butterfly span len = N>>(s+1)
inverse  in  1  0 = forward twiddle ordering, 1 = inverse ordering
ready  in  1  consumer accepts current beat
valid  out  1  beat on outputs is valid
addr_a  out  LANES*LOG2N  lane i at [i*LOG2N +: LOG2N], first operand address
addr_b  out  LANES*LOG2N  lane i, second operand address
tw_idx  out  LANES*LOG2N  lane i, twiddle-table index
last  out  1  current beat is the final beat of the stage
busy  out  1  sweep in progress
done  out  1  one-cycle pulse after the final beat is accepted
err  out  1  one-cycle pulse when start carries an illegal stage

Behaviour:
- Interface: one clock, clk. Reset srst is synchronous, active-high.
- Reset: all outputs are 0, FSM is in IDLE, beat counter is 0. This applies at any point, including mid-sweep. In-flight beats are dropped, with no done pulse.
- FSM states:
  - IDLE.
  - RUN: outputs are valid.
  - FIN: one cycle, done=1, then back to IDLE.
- IDLE with start=1 and stage<=LOG2N-1: latch stage and inverse, set beat counter b=0, go to RUN. valid=1 from the next cycle, so first-beat latency is 1 cycle.
- IDLE with start=1 and stage>LOG2N-1: err=1 for one cycle, stay in IDLE.
- start in any state other than IDLE is ignored. Latched stage and inverse do not change mid-sweep.
- Beats: B = N/(2*LANES), b counts 0..B-1. Lane i handles butterfly k = b*LANES + i.
- Per lane, all unsigned and truncated to LOG2N bits:
  - group = k >> (LOG2N-1-s)
  - off = k & (len-1)
  - addr_a = group*2*len + off
  - addr_b = addr_a + len
  - forward: tw_idx = (1<<s) + group
  - inverse: tw_idx = (2<<s) - 1 - group
- Outputs are registered. In RUN, with valid=1 and ready=0, every output holds stable (no bubbles, no advance).
- valid&&ready with b<B-1: b increments and the next beat is presented the following cycle. Full throughput is 1 beat/cycle.
- last = valid && b==B-1.
- Accept of the last beat: go to FIN. valid=0 and busy=0 on the next cycle, with done=1 in that same cycle.
- start asserted in the FIN cycle is ignored. A new sweep may start the cycle after done.
- busy=1 in RUN only.
- Wrap-around: addresses never exceed N-1 for any legal stage. Stage LOG2N-1 gives len=1 and tw_idx up to N-1.

Test Plan:
- Forward s=0 (N=256, LANES=2), ready=1 -> beat0: a={0,1}, b={128,129}, tw={1,1}. Beat63: a={126,127}, b={254,255}, last=1. done pulses 1 cycle later. 64 beats total.
- Forward s=6 -> beat0: a={0,1}, b={2,3}, tw={64,64}. Beat1: a={4,5}, b={6,7}, tw={65,65}. Beat63: tw={127,127}.
- Inverse s=6 -> beat0: tw={127,127}. Beat1: tw={126,126}. Beat63: tw={64,64}. Addresses are identical to the forward case.
- Backpressure: drop ready for 3 cycles at beat 10 -> outputs frozen at beat 10 values. Exactly 64 accepted beats, no duplicates or skips.
- Start with stage=9 -> err pulse, busy stays 0. Start asserted during RUN -> ignored, sweep completes unchanged.
- srst asserted at beat 20 -> next cycle valid=0, busy=0, done=0. A fresh start then begins again at beat 0.
